renkon_serial_output: RTL and testbench
=======================================

# renkon_serial_output

Output serializer for the renkon core array: snapshots the per-core result bus on a capture strobe, then streams the selected channels one word per cycle, in ascending core order, over a valid/ready handshake. Successor to the fixed single-select output mux: channel count and data width are parameters, emit length is chosen per batch, downstream back-pressure is supported, and optional output ReLU is available. Sits between the core array and the output-memory write port.

## Interface
- DWIDTH, 16, signed word width of core results and output.
- CORE, 8, number of core channels (≥1).
- CORELOG, $clog2(CORE), index width.
- clk  in  1  clock; all state on rising edge.
- xrst  in  1  asynchronous, active-low reset.
- capture  in  1  snapshot strobe for in_data and count.
- count  in  CORELOG+1  channels to emit this batch; 0 = none; values > CORE clamp to CORE.
- in_data  in  CORE×DWIDTH signed  per-core results; element i = core i.
- out_valid  out  1  out_data/out_index hold a word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DWIDTH signed  current word.
- out_index  out  CORELOG  core index of current word.
- busy  out  1  high while state is SEND.
- done  out  1  one-cycle pulse after a batch completes.
- overrun  out  1  one-cycle pulse when a capture is dropped.

## Operation
- Reset (async, xrst=0): state IDLE; bank cleared to 0; idx=0, len=0; out_valid, out_data, out_index, busy, done, overrun all 0.
- States: IDLE, SEND.
- Capture is accepted when state is IDLE, or in SEND during the final handshake (out_valid & out_ready & idx==len-1). On acceptance: bank[i] ← in_data[i] for all i; len ← min(count, CORE); idx ← 0.
- Accepted with len≥1: enter/stay in SEND, out_valid=1, out_data=bank_new[0], out_index=0.
- Accepted with len=0: stay in/return to IDLE, out_valid=0, done pulses next cycle.
- capture high at any other time: ignored; bank unchanged; overrun=1 for one cycle.
- SEND, out_valid & out_ready, idx<len-1: idx++, out_data=bank[idx+1], out_index=idx+1.
- SEND, final handshake without accepted capture: → IDLE, out_valid=0, busy=0, done=1 next cycle.
- Final handshake with accepted capture (back-to-back): done=1 for the old batch and the new batch's word 0 are presented in the same next cycle; no bubble.
- out_valid & !out_ready: all outputs hold; valid never drops without a handshake.
- out_ready is ignored while out_valid=0.

## Timing
- All outputs registered.
- Capture at edge N → first word valid in cycle after edge N (latency 1).
- Continuous out_ready: one word per cycle; batch of L words occupies L cycles; done in the cycle after the last handshake.
- in_data sampled only at the accepting edge; it may change freely afterwards.
- busy = (state==SEND), same cycle as out_valid.

## Configuration
- RENKON_OUTPUT_RELU_EN defined: out_data = (bank[idx] < 0) ? 0 : bank[idx]; applied on the output path, bank keeps the raw value.
- Not defined: out_data = bank[idx] unmodified, negative values pass through.

## Test plan
- Reset: drive xrst=0 mid-SEND with out_valid=1 → out_valid, busy, done, overrun, out_data drop to 0 immediately; after release, no words emitted until a new capture.
- CORE=8, DWIDTH=16, in_data[i]=100+i, count=8, out_ready=1 → out_data 100..107, out_index 0..7 on 8 consecutive cycles, done 1 cycle after; in_data changed to 0 after capture does not affect stream.
- Same batch, out_ready toggled 1,0,0,1,… → each word held stable while ready=0; exact sequence 100..107 without loss or duplication.
- count=0 → no out_valid, done pulses once the cycle after capture; count=12 → exactly 8 words emitted.
- Capture during mid-stream (idx=3) → overrun one cycle, stream continues 104..107 unchanged; capture on final handshake with in_data[i]=200+i, count=2 → done and word 200 in same cycle, then 201.
- With RENKON_OUTPUT_RELU_EN: in_data = {-5, 7, -32768, 0}, count=4 → 0, 7, 0, 0; without the macro → -5, 7, -32768, 0.

Source files
------------

// File: rtl/renkon_serial_output.sv
// Output serializer for the renkon core array: snapshots per-core results and streams them over valid/ready.
// Optional output ReLU is enabled by defining RENKON_OUTPUT_RELU_EN.
module renkon_serial_output #(
  parameter int DWIDTH  = 16,
  parameter int CORE    = 8,
  parameter int CORELOG = $clog2(CORE)
) (
  input  logic                           clk,
  input  logic                           xrst,
  input  logic                           capture,
  input  logic [CORELOG:0]               count,
  input  logic [CORE-1:0][DWIDTH-1:0]    in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DWIDTH-1:0]       out_data,
  output logic [CORELOG-1:0]             out_index,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CORELOG:0] CORE_N = (CORELOG+1)'(CORE);

  state_t                   state;
  logic signed [DWIDTH-1:0] bank [CORE];
  logic [CORELOG-1:0]       idx;
  logic [CORELOG-1:0]       idx_next;
  logic [CORELOG:0]         len;
  logic [CORELOG:0]         len_new;
  logic                     handshake;
  logic                     last_hs;
  logic                     accept;

  // ReLU sits on the output path only; the bank always keeps the raw capture.
  function automatic logic signed [DWIDTH-1:0] relu(input logic signed [DWIDTH-1:0] v);
`ifdef RENKON_OUTPUT_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign handshake = out_valid & out_ready;
  assign last_hs   = handshake && ({1'b0, idx} == len - 1'b1);
  assign accept    = capture && ((state == IDLE) || last_hs);
  assign len_new   = (count > CORE_N) ? CORE_N : count;
  assign idx_next  = idx + 1'b1;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state     <= IDLE;
      for (int i = 0; i < CORE; i++) bank[i] <= '0;
      idx       <= '0;
      len       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= capture & ~accept;
      if (accept) begin
        for (int i = 0; i < CORE; i++) bank[i] <= in_data[i];
        len       <= len_new;
        idx       <= '0;
        out_index <= '0;
        // A capture on the final handshake closes the old batch and opens the new one with no bubble.
        if (len_new != '0) begin
          state     <= SEND;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          out_data  <= relu(in_data[0]);
          done      <= last_hs;
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_data  <= '0;
          done      <= 1'b1;
        end
      end else if (last_hs) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        out_data  <= '0;
        out_index <= '0;
        done      <= 1'b1;
      end else if (handshake) begin
        idx       <= idx_next;
        out_data  <= relu(bank[idx_next]);
        out_index <= idx_next;
      end
    end
  end

endmodule

// File: tb/tb_renkon_serial_output.sv
// Scoreboard bench for renkon_serial_output: directed batches push expected words, a monitor pops on handshake.
module tb_renkon_serial_output;

  localparam int DW   = 16;
  localparam int CORE = 8;
  localparam int CL   = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CL-1:0] i;
  } word_t;

  logic                     clk = 1'b0;
  logic                     xrst = 1'b0;
  logic                     capture = 1'b0;
  logic [CL:0]              count = '0;
  logic [CORE-1:0][DW-1:0]  in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [DW-1:0]     out_data;
  logic [CL-1:0]            out_index;
  logic                     busy;
  logic                     done;
  logic                     overrun;

  word_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = -1;
  int    last_hs = -1;

  renkon_serial_output #(.DWIDTH(DW), .CORE(CORE)) dut (
    .clk(clk), .xrst(xrst), .capture(capture), .count(count), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] v);
`ifdef RENKON_OUTPUT_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the scoreboard head; it is consumed on handshake.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_word: got data %0d index %0d expected no word", out_data, out_index);
      end else begin
        checkOutput("word_data", {16'd0, out_data}, {16'd0, q[0].d});
        checkOutput("word_index", {29'd0, out_index}, {29'd0, q[0].i});
        if (out_ready) begin
          void'(q.pop_front());
          last_hs = cyc;
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic applyStimulus(input int c, input int base);
    int n;
    @(posedge clk);
    #1;
    capture = 1'b1;
    count   = (CL+1)'(c);
    for (int i = 0; i < CORE; i++) in_data[i] = DW'(base + i);
    n = (c > CORE) ? CORE : c;
    for (int i = 0; i < n; i++) q.push_back('{d: relu_model(DW'(base + i)), i: CL'(i)});
    @(posedge clk);
    #1;
    capture = 1'b0;
    count   = '0;
    in_data = '0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d words pending expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic waitIndex(input string name, input int target);
    int k = 0;
    while (!(out_valid && out_index == CL'(target)) && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!(out_valid && out_index == CL'(target))) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got index %0d expected %0d", name, out_index, target);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    bit pat[4];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    #2;
    checkOutput("rst_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_overrun", {31'd0, overrun}, 0);
    checkOutput("rst_data", {16'd0, out_data}, 0);
    checkOutput("rst_index", {29'd0, out_index}, 0);
    #10;
    xrst = 1'b1;
    out_ready = 1'b1;

    // Full batch at full rate, input changes after capture
    dc = done_cnt;
    applyStimulus(8, 100);
    waitDrain("t1", 40);
    repeat (2) @(negedge clk);
    checkOutput("t1_done_count", done_cnt - dc, 1);
    checkOutput("t1_done_latency", done_cyc - last_hs, 1);
    checkOutput("t1_busy_idle", {31'd0, busy}, 0);

    // Back-pressure with ready pattern 1,0,0,1
    dc = done_cnt;
    applyStimulus(8, 100);
    k = 0;
    while (q.size() != 0 && k < 80) begin
      @(posedge clk);
      #1;
      out_ready = pat[k % 4];
      k++;
    end
    out_ready = 1'b1;
    waitDrain("t2", 10);
    repeat (3) @(negedge clk);
    checkOutput("t2_done_count", done_cnt - dc, 1);

    // Empty batch
    dc = done_cnt;
    applyStimulus(0, 0);
    repeat (3) @(negedge clk);
    checkOutput("t3_zero_done_count", done_cnt - dc, 1);
    checkOutput("t3_zero_busy", {31'd0, busy}, 0);

    // Oversized count clamps to CORE
    dc = done_cnt;
    applyStimulus(12, 300);
    waitDrain("t3b", 40);
    repeat (4) @(negedge clk);
    checkOutput("t3_clamp_done_count", done_cnt - dc, 1);

    // Mid-stream capture is dropped; final-handshake capture chains with no bubble
    dc = done_cnt;
    applyStimulus(8, 100);
    waitIndex("t4_idx3", 3);
    capture = 1'b1;
    count   = 4'd2;
    for (int i = 0; i < CORE; i++) in_data[i] = DW'(500 + i);
    @(posedge clk);
    #1;
    capture = 1'b0;
    count   = '0;
    in_data = '0;
    @(negedge clk);
    checkOutput("t4_overrun_pulse", {31'd0, overrun}, 1);
    @(negedge clk);
    checkOutput("t4_overrun_clear", {31'd0, overrun}, 0);
    waitIndex("t4_idx7", 7);
    capture = 1'b1;
    count   = 4'd2;
    for (int i = 0; i < CORE; i++) in_data[i] = DW'(200 + i);
    q.push_back('{d: 16'd200, i: 3'd0});
    q.push_back('{d: 16'd201, i: 3'd1});
    @(posedge clk);
    #1;
    capture = 1'b0;
    count   = '0;
    in_data = '0;
    @(negedge clk);
    checkOutput("t4_chain_done", {31'd0, done}, 1);
    checkOutput("t4_chain_valid", {31'd0, out_valid}, 1);
    checkOutput("t4_chain_overrun", {31'd0, overrun}, 0);
    waitDrain("t4", 20);
    repeat (3) @(negedge clk);
    checkOutput("t4_done_count", done_cnt - dc, 2);

    // Negative values: raw or rectified depending on build
    @(posedge clk);
    #1;
    capture    = 1'b1;
    count      = 4'd4;
    in_data[0] = 16'hFFFB;
    in_data[1] = 16'd7;
    in_data[2] = 16'h8000;
    in_data[3] = 16'd0;
    q.push_back('{d: relu_model(16'hFFFB), i: 3'd0});
    q.push_back('{d: 16'd7, i: 3'd1});
    q.push_back('{d: relu_model(16'h8000), i: 3'd2});
    q.push_back('{d: 16'd0, i: 3'd3});
    @(posedge clk);
    #1;
    capture = 1'b0;
    count   = '0;
    in_data = '0;
    waitDrain("t5", 20);
    repeat (3) @(negedge clk);

    // Asynchronous reset while a word is held
    out_ready = 1'b0;
    applyStimulus(8, 100);
    @(negedge clk);
    checkOutput("t6_valid_before_reset", {31'd0, out_valid}, 1);
    @(posedge clk);
    #1;
    xrst = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'd0, out_valid}, 0);
    checkOutput("t6_rst_busy", {31'd0, busy}, 0);
    checkOutput("t6_rst_done", {31'd0, done}, 0);
    checkOutput("t6_rst_overrun", {31'd0, overrun}, 0);
    checkOutput("t6_rst_data", {16'd0, out_data}, 0);
    q.delete();
    @(negedge clk);
    #1;
    xrst = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("t6_idle_after_reset", {31'd0, out_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
